// File: rtl/fetch_stage_pkg.sv
// Shared widths and payload types for the instruction-fetch stage.
package fetch_stage_pkg;
   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned WORD_W      = 32;
   localparam int unsigned FETCH_DEPTH = 2;
   localparam int unsigned CNT_W       = 2;

   typedef logic [ADDR_W-1:0] rom_addr_t;
   typedef logic [WORD_W-1:0] word_t;

   typedef struct packed {
      word_t     instr;
      rom_addr_t pc;
      rom_addr_t pc_plus4;
   } fetch_packet_t;
endpackage

// File: rtl/fetch_stage_if.sv
// PC, instruction-ROM and decode-side handshake signals of the fetch stage.
interface fetch_stage_if;
   import fetch_stage_pkg::*;

   rom_addr_t pc;
   rom_addr_t pc_plus4;
   logic      pc_advance;
   rom_addr_t imem_addr;
   word_t     imem_data;
   logic      flush;
   logic      out_valid;
   logic      out_ready;
   word_t     out_instr;
   rom_addr_t out_pc;
   rom_addr_t out_pc_plus4;

   modport master (
      input  pc, pc_plus4, imem_data, flush, out_ready,
      output pc_advance, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4
   );

   modport slave (
      output pc, pc_plus4, imem_data, flush, out_ready,
      input  pc_advance, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4
   );
endinterface

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetch packets with synchronous clear; head reads as zero when empty.
module fetch_buffer
   import fetch_stage_pkg::*;
#(
   parameter int unsigned DEPTH = FETCH_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_clear,
   input  fetch_packet_t    i_data,
   output logic [CNT_W-1:0] o_count,
   output fetch_packet_t    o_head
);

   fetch_packet_t    r_mem [FETCH_DEPTH];
   logic             r_head;
   logic             r_tail;
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_head  <= 1'b0;
         r_tail  <= 1'b0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_tail] <= i_data;
            r_tail        <= ~r_tail;
         end
         if (i_pop) begin
            r_head <= ~r_head;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_count = r_count;
   assign o_head  = (r_count != '0) ? r_mem[r_head] : '0;

   // The issue gating upstream must never let a capture land in a full queue.
   a_no_overflow: assert property (@(posedge clk) disable iff (reset || i_clear)
      !(i_push && !i_pop && (r_count == CNT_W'(DEPTH))));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one-deep ROM request register feeding a 2-entry result queue,
// with PC advance gated by queue occupancy and all work killed on flush.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int unsigned DEPTH = FETCH_DEPTH
) (
   input  logic          clk,
   input  logic          reset,
   fetch_stage_if.master bus
);

   logic             r_req_valid;
   rom_addr_t        r_req_pc;
   rom_addr_t        r_req_pc4;

   logic [CNT_W-1:0] w_count;
   logic [CNT_W-1:0] w_occ;
   logic             w_pop;
   logic             w_issue;
   logic             w_push;
   fetch_packet_t    w_cap;
   fetch_packet_t    w_head;

   assign bus.out_valid = (w_count != '0);
   assign w_pop         = bus.out_valid & bus.out_ready;
   assign w_occ         = w_count + CNT_W'(r_req_valid);

   // Issue only when the in-flight request plus queue still leaves a slot at capture time.
   assign w_issue = !reset && !bus.flush &&
                    ((w_occ < CNT_W'(DEPTH)) || ((w_occ == CNT_W'(DEPTH)) && w_pop));

   assign bus.pc_advance = w_issue;
   assign bus.imem_addr  = bus.pc;

   assign w_push = r_req_valid & ~bus.flush;
   assign w_cap  = '{instr: bus.imem_data, pc: r_req_pc, pc_plus4: r_req_pc4};

   always_ff @(posedge clk) begin
      if (reset || bus.flush) begin
         r_req_valid <= 1'b0;
         r_req_pc    <= '0;
         r_req_pc4   <= '0;
      end else begin
         r_req_valid <= w_issue;
         if (w_issue) begin
            r_req_pc  <= bus.pc;
            r_req_pc4 <= bus.pc_plus4;
         end
      end
   end

   fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_clear (bus.flush),
      .i_data  (w_cap),
      .o_count (w_count),
      .o_head  (w_head)
   );

   assign bus.out_instr    = w_head.instr;
   assign bus.out_pc       = w_head.pc;
   assign bus.out_pc_plus4 = w_head.pc_plus4;

endmodule
